// File: rtl/rcb_ram_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rcb_ram_ctrl : HPB write responder; arbitrates lookup reads vs host writes  |
// |                onto one single-port RAM.                                   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module rcb_ram_ctrl #(
    parameter int ADDR_WIDTH   = 10,
    parameter int DATA_WIDTH   = 64,
    parameter int RD_LATENCY   = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    hpb_wr_req_i,
    input  logic [ADDR_WIDTH-1:0]   hpb_wr_addr_i,
    input  logic [DATA_WIDTH-1:0]   hpb_wr_data_i,
    input  logic [DATA_WIDTH/8-1:0] hpb_wr_byte_en_i,
    output logic                    rcb_wr_done_o,
    input  logic                    lkp_req_valid_i,
    input  logic [ADDR_WIDTH-1:0]   lkp_req_addr_i,
    output logic                    lkp_req_ready_o,
    output logic                    lkp_rsp_valid_o,
    output logic [DATA_WIDTH-1:0]   lkp_rsp_data_o,
    output logic                    ram_en_o,
    output logic                    ram_we_o,
    output logic [ADDR_WIDTH-1:0]   ram_addr_o,
    output logic [DATA_WIDTH/8-1:0] ram_be_o,
    output logic [DATA_WIDTH-1:0]   ram_wdata_o,
    input  logic [DATA_WIDTH-1:0]   ram_rdata_i
);

    localparam int BE_WIDTH     = DATA_WIDTH / 8;
    localparam int STARVE_WIDTH = $clog2(STARVE_LIMIT + 2);
    localparam logic [STARVE_WIDTH-1:0] STARVE_MAX = STARVE_WIDTH'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PEND  = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                    state_q;
    logic [STARVE_WIDTH-1:0]   starve_q;
    logic                      done_q;
    logic                      ram_en_q;
    logic                      ram_we_q;
    logic [ADDR_WIDTH-1:0]     ram_addr_q;
    logic [BE_WIDTH-1:0]       ram_be_q;
    logic [DATA_WIDTH-1:0]     ram_wdata_q;
    logic [RD_LATENCY-1:0]     tag_q;
    logic                      rsp_valid_q;
    logic [DATA_WIDTH-1:0]     rsp_data_q;

    logic be_zero;
    logic wr_grant;
    logic rd_accept;

    // A write with no byte enabled never touches the RAM, so it never competes for the port.
    always_comb begin
        be_zero   = ~|hpb_wr_byte_en_i;
        wr_grant  = (state_q == S_PEND) && !be_zero &&
                    (!lkp_req_valid_i || (starve_q == STARVE_MAX));
        rd_accept = lkp_req_valid_i && !wr_grant;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= S_IDLE;
            starve_q    <= '0;
            done_q      <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_be_q    <= '0;
            ram_wdata_q <= '0;
            tag_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            ram_en_q <= 1'b0;
            ram_we_q <= 1'b0;
            if (wr_grant) begin
                ram_en_q    <= 1'b1;
                ram_we_q    <= 1'b1;
                ram_addr_q  <= hpb_wr_addr_i;
                ram_be_q    <= hpb_wr_byte_en_i;
                ram_wdata_q <= hpb_wr_data_i;
            end else if (rd_accept) begin
                ram_en_q   <= 1'b1;
                ram_addr_q <= lkp_req_addr_i;
                ram_be_q   <= '0;
            end

            // Tag travels alongside the RAM read so the response strobe lines up with rdata.
            tag_q[0] <= ram_en_q && !ram_we_q;
            for (int i = 1; i < RD_LATENCY; i++) begin
                tag_q[i] <= tag_q[i-1];
            end
            rsp_valid_q <= tag_q[RD_LATENCY-1];
            if (tag_q[RD_LATENCY-1]) begin
                rsp_data_q <= ram_rdata_i;
            end

            case (state_q)
                S_IDLE: begin
                    starve_q <= '0;
                    if (hpb_wr_req_i) begin
                        state_q <= S_PEND;
                    end
                end
                S_PEND: begin
                    if (be_zero) begin
                        state_q  <= S_DONE;
                        done_q   <= 1'b1;
                        starve_q <= '0;
                    end else if (wr_grant) begin
                        state_q  <= S_WRITE;
                        starve_q <= '0;
                    end else begin
                        starve_q <= starve_q + STARVE_WIDTH'(1);
                    end
                end
                S_WRITE: begin
                    state_q <= S_DONE;
                    done_q  <= 1'b1;
                end
                S_DONE: begin
                    // A held request is not re-executed; only its release matters here.
                    if (!hpb_wr_req_i) begin
                        state_q <= S_IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rcb_wr_done_o   = done_q;
    assign lkp_req_ready_o = !wr_grant;
    assign lkp_rsp_valid_o = rsp_valid_q;
    assign lkp_rsp_data_o  = rsp_data_q;
    assign ram_en_o        = ram_en_q;
    assign ram_we_o        = ram_we_q;
    assign ram_addr_o      = ram_addr_q;
    assign ram_be_o        = ram_be_q;
    assign ram_wdata_o     = ram_wdata_q;

endmodule
`default_nettype wire
